// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the Mini SRC datapath: fetch, decode and
// execute of register-register ALU instructions.
module control_sequencer #(
    parameter int unsigned NREG  = 16,
    parameter int unsigned ALU_W = 5
) (
    input  logic             w_clock,
    input  logic             w_clear,
    input  logic             w_run,
    input  logic             w_mem_ready,
    input  logic [31:0]      w_ir,
    output logic             s_PC,
    output logic             s_Zlow,
    output logic             s_Zhigh,
    output logic             s_MDR,
    output logic             s_HI,
    output logic             s_LO,
    output logic [NREG-1:0]  s_R,
    output logic [NREG-1:0]  e_R,
    output logic             e_MAR,
    output logic             e_Z,
    output logic             e_PC,
    output logic             e_MDR,
    output logic             e_IR,
    output logic             e_Y,
    output logic             e_HI,
    output logic             e_LO,
    output logic             w_IncPC,
    output logic             w_read,
    output logic [ALU_W-1:0] opcode,
    output logic             e_alu,
    output logic             w_halt
);

    typedef enum logic [3:0] {
        StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
    } state_e;

    state_e      state_q, state_d;
    logic [31:15] ir_q;

    logic [4:0]       op;
    logic [3:0]       ra, rb, rc;
    logic [ALU_W-1:0] alu_op;
    logic             legal, unary, muldiv;
    logic [NREG-1:0]  one_hot_base;
    logic             unused_ir_bits;

    // Low IR bits carry immediates this unit never decodes.
    assign unused_ir_bits = ^w_ir[14:0];

    assign op = ir_q[31:27];
    assign ra = ir_q[26:23];
    assign rb = ir_q[22:19];
    assign rc = ir_q[18:15];
    assign one_hot_base = {{(NREG-1){1'b0}}, 1'b1};

    // State register and decode latch; IR is captured on the edge entering T3.
    always_ff @(posedge w_clock or negedge w_clear) begin
        if (!w_clear) begin
            state_q <= StIdle;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StT2) begin
                ir_q <= w_ir[31:15];
            end
        end
    end

    // Map the latched IR opcode onto the ALU operation and instruction class.
    always_comb begin
        alu_op = '0;
        legal  = 1'b1;
        unary  = 1'b0;
        muldiv = 1'b0;
        case (op)
            5'b00011: alu_op = ALU_W'(0);
            5'b00100: alu_op = ALU_W'(1);
            5'b00101: alu_op = ALU_W'(2);
            5'b00110: alu_op = ALU_W'(3);
            5'b00111: alu_op = ALU_W'(8);
            5'b01000: alu_op = ALU_W'(7);
            5'b01001: alu_op = ALU_W'(9);
            5'b01010: alu_op = ALU_W'(10);
            5'b01011: alu_op = ALU_W'(11);
            5'b01111: begin alu_op = ALU_W'(5);  muldiv = 1'b1; end
            5'b10000: begin alu_op = ALU_W'(6);  muldiv = 1'b1; end
            5'b10001: begin alu_op = ALU_W'(12); unary  = 1'b1; end
            5'b10010: begin alu_op = ALU_W'(4);  unary  = 1'b1; end
            default:  legal = 1'b0;
        endcase
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (w_run) state_d = StT0;
            StT0:   state_d = StT1;
            StT1:   if (w_mem_ready) state_d = StT2;
            StT2:   state_d = StT3;
            StT3: begin
                if (!legal)     state_d = StHalt;
                else if (unary) state_d = StT5;
                else            state_d = StT4;
            end
            StT4:   state_d = StT5;
            StT5:   state_d = muldiv ? StT6 : StT7;
            StT6:   state_d = StT7;
            StT7:   state_d = w_run ? StT0 : StIdle;
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    // Moore output decode from registered state and latched IR fields.
    always_comb begin
        s_PC = 1'b0; s_Zlow = 1'b0; s_Zhigh = 1'b0; s_MDR = 1'b0;
        s_HI = 1'b0; s_LO = 1'b0;
        s_R  = '0;   e_R  = '0;
        e_MAR = 1'b0; e_Z = 1'b0; e_PC = 1'b0; e_MDR = 1'b0; e_IR = 1'b0;
        e_Y = 1'b0; e_HI = 1'b0; e_LO = 1'b0;
        w_IncPC = 1'b0; w_read = 1'b0; opcode = '0; e_alu = 1'b0; w_halt = 1'b0;
        unique case (state_q)
            StT0: begin s_PC = 1'b1; e_MAR = 1'b1; w_IncPC = 1'b1; e_Z = 1'b1; end
            StT1: begin s_Zlow = 1'b1; e_PC = 1'b1; w_read = 1'b1; e_MDR = 1'b1; end
            StT2: begin s_MDR = 1'b1; e_IR = 1'b1; end
            StT3: begin
                if (legal) begin
                    s_R = one_hot_base << rb;
                    if (unary) begin
                        opcode = alu_op; e_alu = 1'b1; e_Z = 1'b1;
                    end else begin
                        e_Y = 1'b1;
                    end
                end
            end
            StT4: begin
                s_R = one_hot_base << rc;
                opcode = alu_op; e_alu = 1'b1; e_Z = 1'b1;
            end
            StT5: begin
                s_Zlow = 1'b1;
                if (muldiv) e_LO = 1'b1;
                else        e_R  = one_hot_base << ra;
            end
            StT6:   begin s_Zhigh = 1'b1; e_HI = 1'b1; end
            StHalt: w_halt = 1'b1;
            default: ;
        endcase
    end

endmodule
